// File: rtl/safety_core_mem_arbiter_if.sv
// OBI-style request/response bundle shared by the core-side ports and the memory port.
// The arbiter sits on the slave side of the core ports and the master side of the memory port.
interface safety_core_mem_arbiter_if #(
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 32
);

  logic                   req;
  logic                   gnt;
  logic                   we;
  logic [DataWidth/8-1:0] be;
  logic [AddrWidth-1:0]   addr;
  logic [DataWidth-1:0]   wdata;
  logic                   rvalid;
  logic [DataWidth-1:0]   rdata;
  logic                   err;

  modport master (
    output req,
    output we,
    output be,
    output addr,
    output wdata,
    input  gnt,
    input  rvalid,
    input  rdata,
    input  err
  );

  modport slave (
    input  req,
    input  we,
    input  be,
    input  addr,
    input  wdata,
    output gnt,
    output rvalid,
    output rdata,
    output err
  );

endinterface

// File: rtl/safety_core_mem_arbiter.sv
// Round-robin arbiter sharing one OBI memory port between the data (port 0) and shadow (port 1)
// interfaces; an in-order ID FIFO records the source of each granted access to route responses.
module safety_core_mem_arbiter #(
  parameter int unsigned AddrWidth      = 32,
  parameter int unsigned DataWidth      = 32,
  parameter int unsigned MaxOutstanding = 2
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  safety_core_mem_arbiter_if.slave             data_bus,
  safety_core_mem_arbiter_if.slave             shadow_bus,
  safety_core_mem_arbiter_if.master            mem_bus,
  output logic [$clog2(MaxOutstanding+1)-1:0]  outstanding_o,
  output logic                                 spurious_rsp_o
);

  localparam int unsigned BeWidth  = DataWidth / 8;
  localparam int unsigned CntWidth = $clog2(MaxOutstanding + 1);
  localparam int unsigned PtrWidth = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;

  localparam logic PortData   = 1'b0;
  localparam logic PortShadow = 1'b1;

  logic [1:0] req;

  logic lock_q, lock_d;
  logic lock_port_q, lock_port_d;
  logic rr_q, rr_d;

  logic [MaxOutstanding-1:0] id_q, id_d;
  logic [PtrWidth-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PtrWidth-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CntWidth-1:0]       count_q, count_d;

  logic full, empty;
  logic win, win_vld;
  logic mem_req, accept, pop, head;
  logic rsp_data, rsp_shadow;

  logic                 win_we;
  logic [BeWidth-1:0]   win_be;
  logic [AddrWidth-1:0] win_addr;
  logic [DataWidth-1:0] win_wdata;

  function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] p);
    return (p == PtrWidth'(MaxOutstanding - 1)) ? '0 : p + 1'b1;
  endfunction

  assign req   = {shadow_bus.req, data_bus.req};
  assign full  = (count_q == CntWidth'(MaxOutstanding));
  assign empty = (count_q == '0);

  // A stalled request keeps the port it was issued for, regardless of the rr pointer.
  always_comb begin
    win     = PortData;
    win_vld = 1'b0;
    if (lock_q) begin
      win     = lock_port_q;
      win_vld = req[lock_port_q];
    end else begin
      unique case (req)
        2'b01: begin
          win     = PortData;
          win_vld = 1'b1;
        end
        2'b10: begin
          win     = PortShadow;
          win_vld = 1'b1;
        end
        2'b11: begin
          win     = rr_q;
          win_vld = 1'b1;
        end
        default: begin
          win     = PortData;
          win_vld = 1'b0;
        end
      endcase
    end
  end

  assign mem_req = win_vld & ~full;
  assign accept  = mem_req & mem_bus.gnt;
  assign pop     = mem_bus.rvalid & ~empty;
  assign head    = id_q[rd_ptr_q];

  always_comb begin
    win_we    = 1'b0;
    win_be    = '0;
    win_addr  = '0;
    win_wdata = '0;
    if (mem_req) begin
      if (win == PortShadow) begin
        win_we    = shadow_bus.we;
        win_be    = shadow_bus.be;
        win_addr  = shadow_bus.addr;
        win_wdata = shadow_bus.wdata;
      end else begin
        win_we    = data_bus.we;
        win_be    = data_bus.be;
        win_addr  = data_bus.addr;
        win_wdata = data_bus.wdata;
      end
    end
  end

  assign mem_bus.req   = mem_req;
  assign mem_bus.we    = win_we;
  assign mem_bus.be    = win_be;
  assign mem_bus.addr  = win_addr;
  assign mem_bus.wdata = win_wdata;

  assign data_bus.gnt   = accept & (win == PortData);
  assign shadow_bus.gnt = accept & (win == PortShadow);

  assign rsp_data   = pop & (head == PortData);
  assign rsp_shadow = pop & (head == PortShadow);

  assign data_bus.rvalid   = rsp_data;
  assign data_bus.rdata    = rsp_data ? mem_bus.rdata : '0;
  assign data_bus.err      = rsp_data & mem_bus.err;
  assign shadow_bus.rvalid = rsp_shadow;
  assign shadow_bus.rdata  = rsp_shadow ? mem_bus.rdata : '0;
  assign shadow_bus.err    = rsp_shadow & mem_bus.err;

  assign spurious_rsp_o = mem_bus.rvalid & empty;
  assign outstanding_o  = count_q;

  always_comb begin
    lock_d      = lock_q;
    lock_port_d = lock_port_q;
    rr_d        = rr_q;
    id_d        = id_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;

    if (accept) begin
      lock_d         = 1'b0;
      rr_d           = ~win;
      id_d[wr_ptr_q] = win;
      wr_ptr_d       = ptr_inc(wr_ptr_q);
    end else if (mem_req) begin
      lock_d      = 1'b1;
      lock_port_d = win;
    end

    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end

    unique case ({accept, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lock_q      <= 1'b0;
      lock_port_q <= PortData;
      rr_q        <= PortData;
      id_q        <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      lock_q      <= lock_d;
      lock_port_q <= lock_port_d;
      rr_q        <= rr_d;
      id_q        <= id_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

  a_count_bound : assert property (@(posedge clk_i) disable iff (!rst_ni)
    count_q <= CntWidth'(MaxOutstanding));

  // Requesters must hold the payload of a stalled access until it is granted.
  a_locked_stable : assert property (@(posedge clk_i) disable iff (!rst_ni)
    (lock_q && mem_req && $past(mem_req)) |-> ($stable(win_addr) && $stable(win_we)));

endmodule

// File: tb/tb_safety_core_mem_arbiter.sv
// Self-checking bench: directed scenarios with literal expectations plus a randomized run,
// all compared every cycle against a queue-based behavioural model of the arbiter.
module tb_safety_core_mem_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned MO = 2;
  localparam int unsigned BW = DW / 8;
  localparam int unsigned CW = $clog2(MO + 1);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  safety_core_mem_arbiter_if #(.AddrWidth(AW), .DataWidth(DW)) data_if ();
  safety_core_mem_arbiter_if #(.AddrWidth(AW), .DataWidth(DW)) shadow_if ();
  safety_core_mem_arbiter_if #(.AddrWidth(AW), .DataWidth(DW)) mem_if ();

  logic [1:0]    t_req;
  logic [1:0]    t_we;
  logic [BW-1:0] t_be    [2];
  logic [AW-1:0] t_addr  [2];
  logic [DW-1:0] t_wdata [2];
  logic          t_mgnt, t_mrv, t_merr;
  logic [DW-1:0] t_mrdata;

  logic [CW-1:0] outstanding;
  logic          spurious;

  assign data_if.req     = t_req[0];
  assign data_if.we      = t_we[0];
  assign data_if.be      = t_be[0];
  assign data_if.addr    = t_addr[0];
  assign data_if.wdata   = t_wdata[0];
  assign shadow_if.req   = t_req[1];
  assign shadow_if.we    = t_we[1];
  assign shadow_if.be    = t_be[1];
  assign shadow_if.addr  = t_addr[1];
  assign shadow_if.wdata = t_wdata[1];
  assign mem_if.gnt      = t_mgnt;
  assign mem_if.rvalid   = t_mrv;
  assign mem_if.rdata    = t_mrdata;
  assign mem_if.err      = t_merr;

  safety_core_mem_arbiter #(
    .AddrWidth      (AW),
    .DataWidth      (DW),
    .MaxOutstanding (MO)
  ) u_dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .data_bus       (data_if),
    .shadow_bus     (shadow_if),
    .mem_bus        (mem_if),
    .outstanding_o  (outstanding),
    .spurious_rsp_o (spurious)
  );

  int errors = 0;
  int checks = 0;

  // Model state: queue of port IDs in flight, preferred port, pending stalled request.
  int       mq[$];
  int       rr  = 0;
  bit       lk  = 1'b0;
  int       lkp = 0;
  bit [1:0] done = 2'b00;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_step();
    int n;
    int w;
    int head;
    bit full, wv, mreq, acc, pop, rd, rs;
    n    = mq.size();
    full = (n == MO);
    if (lk) begin
      w  = lkp;
      wv = t_req[w];
    end else if (t_req == 2'b11) begin
      w  = rr;
      wv = 1'b1;
    end else if (t_req[1]) begin
      w  = 1;
      wv = 1'b1;
    end else begin
      w  = 0;
      wv = t_req[0];
    end
    mreq = wv && !full;
    acc  = mreq && t_mgnt;
    pop  = t_mrv && (n > 0);
    head = pop ? mq[0] : 0;
    rd   = pop && (head == 0);
    rs   = pop && (head == 1);

    chk("m_mem_req",     64'(mem_if.req),      64'(mreq));
    chk("m_mem_we",      64'(mem_if.we),       mreq ? 64'(t_we[w]) : 64'd0);
    chk("m_mem_be",      64'(mem_if.be),       mreq ? 64'(t_be[w]) : 64'd0);
    chk("m_mem_addr",    64'(mem_if.addr),     mreq ? 64'(t_addr[w]) : 64'd0);
    chk("m_mem_wdata",   64'(mem_if.wdata),    mreq ? 64'(t_wdata[w]) : 64'd0);
    chk("m_data_gnt",    64'(data_if.gnt),     64'(acc && (w == 0)));
    chk("m_shadow_gnt",  64'(shadow_if.gnt),   64'(acc && (w == 1)));
    chk("m_data_rvalid", 64'(data_if.rvalid),  64'(rd));
    chk("m_data_rdata",  64'(data_if.rdata),   rd ? 64'(t_mrdata) : 64'd0);
    chk("m_data_err",    64'(data_if.err),     64'(rd && t_merr));
    chk("m_shd_rvalid",  64'(shadow_if.rvalid), 64'(rs));
    chk("m_shd_rdata",   64'(shadow_if.rdata), rs ? 64'(t_mrdata) : 64'd0);
    chk("m_shd_err",     64'(shadow_if.err),   64'(rs && t_merr));
    chk("m_spurious",    64'(spurious),        64'(t_mrv && (n == 0)));
    chk("m_outstanding", 64'(outstanding),     64'(n));

    if (pop) void'(mq.pop_front());
    if (acc) begin
      mq.push_back(w);
      rr      = 1 - w;
      lk      = 1'b0;
      done[w] = 1'b1;
    end else if (mreq) begin
      lk  = 1'b1;
      lkp = w;
    end
  endtask

  always @(negedge clk) begin
    #3;
    if (!rst_n) begin
      mq.delete();
      rr  = 0;
      lk  = 1'b0;
      lkp = 0;
    end else begin
      model_step();
    end
  end

  task automatic idle();
    t_req    = 2'b00;
    t_we     = 2'b00;
    t_mgnt   = 1'b0;
    t_mrv    = 1'b0;
    t_merr   = 1'b0;
    t_mrdata = '0;
    for (int p = 0; p < 2; p++) begin
      t_be[p]    = '0;
      t_addr[p]  = '0;
      t_wdata[p] = '0;
    end
  endtask

  task automatic reset_dut();
    @(negedge clk);
    idle();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    done  = 2'b00;
  endtask

  initial begin
    idle();

    // Single data read at 0x1000, granted after one stall, response two cycles later.
    reset_dut();
    @(negedge clk);
    t_req[0] = 1'b1; t_addr[0] = 32'h1000; t_be[0] = '1;
    #4;
    chk("t1_mem_req", 64'(mem_if.req), 64'd1);
    chk("t1_mem_addr", 64'(mem_if.addr), 64'h1000);
    chk("t1_gnt_stall", 64'(data_if.gnt), 64'd0);
    @(negedge clk);
    t_mgnt = 1'b1;
    #4;
    chk("t1_data_gnt", 64'(data_if.gnt), 64'd1);
    chk("t1_shadow_gnt", 64'(shadow_if.gnt), 64'd0);
    @(negedge clk);
    t_req = 2'b00; t_mgnt = 1'b0;
    #4;
    chk("t1_outstanding", 64'(outstanding), 64'd1);
    @(negedge clk);
    t_mrv = 1'b1; t_mrdata = 32'hCAFE0001;
    #4;
    chk("t1_data_rvalid", 64'(data_if.rvalid), 64'd1);
    chk("t1_data_rdata", 64'(data_if.rdata), 64'hCAFE0001);
    chk("t1_shadow_rvalid", 64'(shadow_if.rvalid), 64'd0);
    @(negedge clk);
    t_mrv = 1'b0;
    #4;
    chk("t1_drained", 64'(outstanding), 64'd0);

    // Both ports request every cycle, memory always grants: D,S,D,S with in-order responses.
    reset_dut();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      t_req = 2'b11; t_addr[0] = 32'h2000; t_addr[1] = 32'h3000; t_mgnt = 1'b1;
      t_mrv = (i > 0); t_mrdata = 32'h100 + i;
      #4;
      chk("t2_data_gnt", 64'(data_if.gnt), 64'((i % 2) == 0));
      chk("t2_shadow_gnt", 64'(shadow_if.gnt), 64'((i % 2) == 1));
      chk("t2_mem_addr", 64'(mem_if.addr), ((i % 2) == 0) ? 64'h2000 : 64'h3000);
      if (i > 0) begin
        chk("t2_data_rvalid", 64'(data_if.rvalid), 64'(((i - 1) % 2) == 0));
        chk("t2_shadow_rvalid", 64'(shadow_if.rvalid), 64'(((i - 1) % 2) == 1));
      end
    end
    @(negedge clk);
    t_req = 2'b00; t_mgnt = 1'b0; t_mrv = 1'b1;
    #4;
    chk("t2_last_rsp_shadow", 64'(shadow_if.rvalid), 64'd1);

    // Shadow stalled for three cycles while data rises: shadow stays locked, data follows.
    reset_dut();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      t_req = (i == 0) ? 2'b10 : 2'b11;
      t_addr[1] = 32'h3300; t_addr[0] = 32'h2200;
      #4;
      chk("t3_locked_addr", 64'(mem_if.addr), 64'h3300);
      chk("t3_data_gnt0", 64'(data_if.gnt), 64'd0);
    end
    @(negedge clk);
    t_mgnt = 1'b1;
    #4;
    chk("t3_shadow_gnt", 64'(shadow_if.gnt), 64'd1);
    chk("t3_data_gnt_loser", 64'(data_if.gnt), 64'd0);
    @(negedge clk);
    t_req = 2'b01;
    #4;
    chk("t3_data_next", 64'(data_if.gnt), 64'd1);
    chk("t3_data_addr", 64'(mem_if.addr), 64'h2200);

    // Full FIFO blocks new requests, even in the cycle a response pops.
    reset_dut();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      t_req = 2'b01; t_addr[0] = 32'h4000 + 4 * i; t_mgnt = 1'b1;
    end
    @(negedge clk);
    t_addr[0] = 32'h4008;
    #4;
    chk("t4_full_req", 64'(mem_if.req), 64'd0);
    chk("t4_full_cnt", 64'(outstanding), 64'd2);
    chk("t4_full_gnt", 64'(data_if.gnt), 64'd0);
    @(negedge clk);
    t_mrv = 1'b1;
    #4;
    chk("t4_pop_req", 64'(mem_if.req), 64'd0);
    chk("t4_pop_rvalid", 64'(data_if.rvalid), 64'd1);
    @(negedge clk);
    t_mrv = 1'b0;
    #4;
    chk("t4_third_req", 64'(mem_if.req), 64'd1);
    chk("t4_third_gnt", 64'(data_if.gnt), 64'd1);
    chk("t4_third_cnt", 64'(outstanding), 64'd1);

    // Response with nothing in flight.
    reset_dut();
    @(negedge clk);
    t_mrv = 1'b1;
    #4;
    chk("t5_spurious", 64'(spurious), 64'd1);
    chk("t5_no_data_rv", 64'(data_if.rvalid), 64'd0);
    chk("t5_no_shadow_rv", 64'(shadow_if.rvalid), 64'd0);
    @(negedge clk);
    t_mrv = 1'b0;
    #4;
    chk("t5_spurious_end", 64'(spurious), 64'd0);

    // Asynchronous reset with two accesses in flight; the late response is spurious.
    reset_dut();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      t_req = 2'b01; t_addr[0] = 32'h5000 + 4 * i; t_mgnt = 1'b1;
    end
    @(negedge clk);
    idle();
    #1 rst_n = 1'b0;
    #1;
    chk("t6_rst_cnt", 64'(outstanding), 64'd0);
    chk("t6_rst_req", 64'(mem_if.req), 64'd0);
    chk("t6_rst_gnt", 64'(data_if.gnt), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    done  = 2'b00;
    @(negedge clk);
    t_mrv = 1'b1;
    #4;
    chk("t6_late_spurious", 64'(spurious), 64'd1);
    chk("t6_late_no_rv", 64'(data_if.rvalid), 64'd0);
    @(negedge clk);
    t_mrv = 1'b0;

    // Randomized traffic; requesters hold req and payload until granted.
    reset_dut();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      if (cyc == 1500) begin
        idle();
        #1 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        done  = 2'b00;
        continue;
      end
      for (int p = 0; p < 2; p++) begin
        if (!t_req[p] || done[p]) begin
          done[p]    = 1'b0;
          t_req[p]   = ($urandom_range(0, 99) < 55);
          t_we[p]    = $urandom_range(0, 1) == 1;
          t_be[p]    = BW'($urandom);
          t_addr[p]  = AW'($urandom);
          t_wdata[p] = DW'($urandom);
        end
      end
      t_mgnt   = ($urandom_range(0, 99) < 60);
      t_mrv    = (mq.size() > 0) ? ($urandom_range(0, 99) < 45) : ($urandom_range(0, 99) < 3);
      t_mrdata = DW'($urandom);
      t_merr   = ($urandom_range(0, 9) == 0);
    end
    @(negedge clk);
    idle();
    @(negedge clk);
    #4;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
